// File: rtl/mii_pkg.sv
// Shared definitions for the MII/GMII receive capture path.
package mii_pkg;

  // Bytes that delimit the start of an Ethernet frame on the receive stream.
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // Width of the frame length counter; big enough for MAX_LEN up to 2047
  // plus the one extra byte that triggers the oversize drop.
  localparam int LEN_W = 12;

  // Receive framing state machine.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } rx_state_e;

endpackage : mii_pkg

// File: rtl/mii_rx_ram.sv
// Simple dual-port frame buffer: one synchronous write port, one read port
// with a registered output that only advances when a read is requested.
module mii_rx_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write port: storage array is not reset, contents are only read once committed.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: registered read data holds its value when no read is issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : mii_rx_ram

// File: rtl/mii_rx_capture.sv
// Receive capture: strips preamble/SFD, buffers whole frames in a
// commit-on-end FIFO, drops runt/oversize/overflowing frames, and streams
// committed bytes out with valid/ready and an end-of-frame marker.
module mii_rx_capture
  import mii_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        mii_clk,
  input  logic        reset,
  input  logic [7:0]  mii_in,
  input  logic        mii_en,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count
);

  localparam int                PTR_W     = ADDR_W + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]  FULL_USED = PTR_W'(2**ADDR_W);
  localparam logic [LEN_W-1:0]  MIN_LEN_C = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0]  MAX_LEN_C = LEN_W'(MAX_LEN);

  // Write-side state
  rx_state_e         state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  commit_ptr_q, commit_ptr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              pend_valid_q, pend_valid_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  // Read-side state: RAM output stage (s1) feeding the output register
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              s1_valid_q, s1_valid_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  // Combinational helpers
  logic [PTR_W-1:0]  used_s;
  logic              full_s;
  logic              we_s;
  logic [8:0]        wdata_s;
  logic              re_s;
  logic              load_out_s;
  logic [8:0]        rdata_s;

  // Occupancy uses the read pointer before any read this cycle, so the
  // full decision is conservative when a read and write coincide.
  assign used_s = wr_ptr_q - rd_ptr_q;
  assign full_s = (used_s == FULL_USED);

  mii_rx_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (9)
  ) u_ram (
    .clk_i   (mii_clk),
    .rst_ni  (reset),
    .we_i    (we_s),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (wdata_s),
    .re_i    (re_s),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rdata_s)
  );

  // Framing FSM next-state plus FIFO write, commit/rewind and counters.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    len_d        = len_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    we_s         = 1'b0;
    wdata_s      = 9'h000;
    case (state_q)
      IDLE, PREAMBLE: begin
        len_d        = '0;
        pend_valid_d = 1'b0;
        if (mii_en) begin
          if (mii_in == PREAMBLE_BYTE) begin
            state_d = PREAMBLE;
          end else if (mii_in == SFD_BYTE) begin
            state_d = DATA;
          end else begin
            state_d    = DROP;
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (mii_en) begin
          if (full_s || (len_q >= MAX_LEN_C)) begin
            // Abandon the frame: discard everything written since the last commit.
            wr_ptr_d     = commit_ptr_q;
            pend_valid_d = 1'b0;
            len_d        = '0;
            state_d      = DROP;
            drop_cnt_d   = drop_cnt_q + 16'd1;
          end else begin
            // Hold the newest byte back so the true last byte can carry last=1.
            pend_valid_d = 1'b1;
            pend_data_d  = mii_in;
            len_d        = len_q + LEN_W'(1);
            if (pend_valid_q) begin
              we_s     = 1'b1;
              wdata_s  = {1'b0, pend_data_q};
              wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
              wr_ptr_d = wr_ptr_q;
            end
          end
        end else begin
          pend_valid_d = 1'b0;
          len_d        = '0;
          state_d      = IDLE;
          if ((len_q >= MIN_LEN_C) && pend_valid_q && !full_s) begin
            we_s         = 1'b1;
            wdata_s      = {1'b1, pend_data_q};
            wr_ptr_d     = wr_ptr_q + PTR_ONE;
            commit_ptr_d = wr_ptr_q + PTR_ONE;
            frame_cnt_d  = frame_cnt_q + 16'd1;
          end else begin
            wr_ptr_d   = commit_ptr_q;
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
      end
      DROP: begin
        len_d        = '0;
        pend_valid_d = 1'b0;
        if (mii_en) begin
          state_d = DROP;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        len_d        = '0;
        pend_valid_d = 1'b0;
      end
    endcase
  end

  // Read pipeline: prefetch committed bytes into the RAM output stage and
  // move them into the output register whenever it is empty or accepted.
  always_comb begin
    load_out_s  = s1_valid_q && (!out_valid_q || out_ready);
    re_s        = (rd_ptr_q != commit_ptr_q) && (!s1_valid_q || load_out_s);
    rd_ptr_d    = rd_ptr_q;
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (re_s) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      s1_valid_d = 1'b1;
    end else if (load_out_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (load_out_s) begin
      out_valid_d = 1'b1;
      out_data_d  = rdata_s[7:0];
      out_last_d  = rdata_s[8];
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State register for FSM, pointers, counters and output stage.
  always_ff @(posedge mii_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      len_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= 8'h00;
      frame_cnt_q  <= 16'h0000;
      drop_cnt_q   <= 16'h0000;
      rd_ptr_q     <= '0;
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      len_q        <= len_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      s1_valid_q   <= s1_valid_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign out_valid   = out_valid_q;
  assign frame_count = frame_cnt_q;
  assign drop_count  = drop_cnt_q;

endmodule : mii_rx_capture

// File: tb/tb_mii_rx_capture.sv
// Scoreboard bench for mii_rx_capture: a default-size instance (a) and a
// 64-byte FIFO instance (b) share one stimulus bus, steered by sel.
module tb_mii_rx_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_en;
  logic        sel;
  logic        en_a, en_b;

  logic [7:0]  out_data_a, out_data_b;
  logic        out_last_a, out_last_b;
  logic        out_valid_a, out_valid_b;
  logic        out_ready_a, out_ready_b;
  logic [15:0] fc_a, fc_b, dc_a, dc_b;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [8:0]  exp_a[$];
  logic [8:0]  exp_b[$];
  logic [8:0]  pop_a, pop_b;

  always #5 clk = ~clk;

  assign en_a = rx_en & ~sel;
  assign en_b = rx_en & sel;

  mii_rx_capture #(.ADDR_W(11), .MIN_LEN(64), .MAX_LEN(1522)) u_dut_a (
    .mii_clk(clk), .reset(rst_n), .mii_in(rx_data), .mii_en(en_a),
    .out_data(out_data_a), .out_last(out_last_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .frame_count(fc_a), .drop_count(dc_a)
  );

  mii_rx_capture #(.ADDR_W(6), .MIN_LEN(64), .MAX_LEN(1522)) u_dut_b (
    .mii_clk(clk), .reset(rst_n), .mii_in(rx_data), .mii_en(en_b),
    .out_data(out_data_b), .out_last(out_last_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .frame_count(fc_b), .drop_count(dc_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: every accepted output byte must match the head of its queue.
  always @(negedge clk) begin
    if (out_valid_a && out_ready_a) begin
      if (exp_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL out_a_unexpected: got %0h expected none", {out_last_a, out_data_a});
      end else begin
        pop_a = exp_a.pop_front();
        check("out_a_byte", {23'd0, out_last_a, out_data_a}, {23'd0, pop_a});
      end
    end
    if (out_valid_b && out_ready_b) begin
      if (exp_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL out_b_unexpected: got %0h expected none", {out_last_b, out_data_b});
      end else begin
        pop_b = exp_b.pop_front();
        check("out_b_byte", {23'd0, out_last_b, out_data_b}, {23'd0, pop_b});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Preamble bytes, SFD, then nlen payload bytes start, start+1, ...
  // Expected bytes are queued only for frames that should be committed.
  task automatic send_frame(input int npre, input int nlen, input logic [7:0] start,
                            input bit good);
    logic [7:0] b;
    for (int i = 0; i < npre; i++) begin
      rx_en = 1'b1; rx_data = 8'h55; tick();
    end
    rx_en = 1'b1; rx_data = 8'hD5; tick();
    for (int i = 0; i < nlen; i++) begin
      b = start + 8'(i);
      rx_data = b;
      if (good) begin
        if (sel) exp_b.push_back({(i == nlen - 1), b});
        else     exp_a.push_back({(i == nlen - 1), b});
      end
      tick();
    end
    rx_en = 1'b0; rx_data = 8'h00;
  endtask

  task automatic wait_drain(input bit use_b, input string name);
    int k;
    k = 0;
    while (((use_b ? exp_b.size() : exp_a.size()) != 0) && (k < 4000)) begin
      tick(); k++;
    end
    check(name, use_b ? exp_b.size() : exp_a.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rx_en = 1'b0; rx_data = 8'h00; sel = 1'b0;
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    repeat (3) tick();
    check("rst_valid", out_valid_a, 32'd0);
    check("rst_data",  out_data_a,  32'd0);
    check("rst_last",  out_last_a,  32'd0);
    check("rst_fc",    fc_a,        32'd0);
    check("rst_dc",    dc_a,        32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Good 64-byte frame with full preamble; output latency check.
    send_frame(7, 64, 8'h00, 1'b1);
    @(posedge clk); @(negedge clk);
    check("t1_fc_commit_edge", fc_a, 32'd1);
    check("t1_valid_T", out_valid_a, 32'd0);
    @(posedge clk); @(negedge clk);
    check("t1_valid_T1", out_valid_a, 32'd0);
    @(posedge clk); @(negedge clk);
    check("t1_valid_T2", out_valid_a, 32'd1);
    wait_drain(1'b0, "t1_drain");

    // 63-byte runt is dropped.
    tick();
    send_frame(1, 63, 8'hA0, 1'b0);
    tick();
    check("t2_dc", dc_a, 32'd1);
    check("t2_fc", fc_a, 32'd1);

    // Bad byte after preamble, then a good frame.
    rx_en = 1'b1; rx_data = 8'h55; tick();
    rx_data = 8'h12; tick();
    rx_data = 8'h34; tick();
    rx_en = 1'b0; tick();
    send_frame(7, 64, 8'h80, 1'b1);
    tick();
    check("t3_dc", dc_a, 32'd2);
    check("t3_fc", fc_a, 32'd2);
    wait_drain(1'b0, "t3_drain");

    // SFD with no data, then a garbage first byte from IDLE.
    rx_en = 1'b1; rx_data = 8'h55; tick();
    rx_data = 8'hD5; tick();
    rx_en = 1'b0; tick();
    check("t4_sfd_only_dc", dc_a, 32'd3);
    rx_en = 1'b1; rx_data = 8'h07; tick();
    rx_en = 1'b0; tick();
    check("t4_garbage_dc", dc_a, 32'd4);

    // Back-to-back frames with a single-cycle gap.
    send_frame(2, 64, 8'h10, 1'b1);
    tick();
    send_frame(2, 65, 8'h60, 1'b1);
    tick();
    check("t5_fc", fc_a, 32'd4);
    wait_drain(1'b0, "t5_drain");

    // Exactly MAX_LEN passes; longer frame dropped once.
    send_frame(1, 1522, 8'h00, 1'b1);
    tick();
    check("t6_max_fc", fc_a, 32'd5);
    wait_drain(1'b0, "t6_drain");
    send_frame(1, 1530, 8'h00, 1'b0);
    tick();
    check("t6_over_dc", dc_a, 32'd5);
    check("t6_over_fc", fc_a, 32'd5);

    // Small FIFO overflow with downstream stalled.
    sel = 1'b1; out_ready_b = 1'b0;
    tick();
    send_frame(7, 64, 8'h40, 1'b1);
    tick();
    send_frame(7, 64, 8'hC0, 1'b0);
    tick();
    check("t7_fc_b", fc_b, 32'd1);
    check("t7_dc_b", dc_b, 32'd1);
    repeat (5) tick();
    check("t7_hold_valid", out_valid_b, 32'd1);
    check("t7_hold_data",  out_data_b,  32'h40);
    check("t7_hold_last",  out_last_b,  32'd0);
    out_ready_b = 1'b1;
    wait_drain(1'b1, "t7_drain");
    repeat (10) tick();
    check("t7_empty_after", out_valid_b, 32'd0);
    sel = 1'b0;

    // Reset mid-frame with a committed frame queued.
    out_ready_a = 1'b0;
    send_frame(1, 64, 8'h20, 1'b1);
    repeat (5) tick();
    check("t8_queued_valid", out_valid_a, 32'd1);
    check("t8_queued_data",  out_data_a,  32'h20);
    rx_en = 1'b1; rx_data = 8'h55; tick();
    rx_data = 8'hD5; tick();
    for (int i = 0; i < 10; i++) begin
      rx_data = 8'(i); tick();
    end
    rst_n = 1'b0;
    #1;
    check("t8_rst_valid", out_valid_a, 32'd0);
    check("t8_rst_data",  out_data_a,  32'd0);
    check("t8_rst_fc",    fc_a,        32'd0);
    check("t8_rst_dc",    dc_a,        32'd0);
    exp_a.delete();
    exp_b.delete();
    rx_en = 1'b0; rx_data = 8'h00;
    tick();
    rst_n = 1'b1; out_ready_a = 1'b1;
    repeat (50) tick();
    check("t8_post_valid", out_valid_a, 32'd0);
    check("t8_post_fc",    fc_a,        32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mii_rx_capture
